beam_sum_i2s_tx: RTL
====================

Name: beam_sum_i2s_tx

Overview:
Downstream output stage of the beamformer. It takes one delayed PCM sample per channel from the channel buffers and averages them into a single beam sample. It then serializes that sample as I2S (MSB first, one-slot delay after each ws edge) on the board's data and ws outputs. The same beam word is sent in both the left and right halves of each frame (mono beam).

Parameters:
NUMBER_OF_BITS, 8, PCM sample width, two's complement
NUM_CHANNELS, 2, number of channel samples summed; must be a power of two, ≥1
WS_HALF_PERIOD, 16, clk cycles (bit slots) per ws half; must be ≥ NUMBER_OF_BITS+1

Ports:
clk  input  1  single clock; all state changes on posedge
rst_n  input  1  synchronous active-low reset
enable  input  1  run request, sampled at frame boundaries
data_in  input  NUM_CHANNELS*NUMBER_OF_BITS  channel samples packed; channel 0 in the LSBs
in_valid  input  1  data_in holds a new sample set
in_ready  output  1  holding register empty; can accept a sample set
sd  output  1  I2S serial data
ws  output  1  I2S word select; 0 = left half, 1 = right half
underrun  output  1  one-cycle pulse when a frame starts with no sample held

Behaviour:
- Reset (rst_n low at posedge) forces:
  - state IDLE, ws=0, sd=0, underrun=0;
  - holding register empty, so in_ready=1;
  - slot counter 0 and tx word 0.
- All outputs are registered.
- Accept: when in_valid && in_ready at a posedge, the hold register captures the mean and hold_valid is set. in_ready = !hold_valid.
- Mean computation:
  - Sign-extend each channel to NUMBER_OF_BITS+log2(NUM_CHANNELS) bits and sum.
  - Arithmetic right shift by log2(NUM_CHANNELS), flooring toward −inf.
  - Truncate to NUMBER_OF_BITS bits. The result cannot overflow.
- States: IDLE, LEFT, RIGHT. Slot counter runs 0..WS_HALF_PERIOD-1 inside LEFT and RIGHT.
- IDLE:
  - ws=0, sd=0.
  - If enable=1, the next cycle enters LEFT slot 0.
- LEFT slot 0 is the frame start, entered from IDLE or from RIGHT's last slot:
  - If hold_valid: tx_word ← hold and hold_valid is cleared.
  - Otherwise: tx_word ← 0 and underrun pulses for exactly one cycle.
- Simultaneous accept and frame start with an empty hold: the frame counts as an underrun (zeros sent). The accepted sample stays held for the next frame.
- ws value: 0 throughout LEFT, 1 throughout RIGHT. ws changes in the same cycle the state enters slot 0.
- sd slot mapping in each half:
  - slot 0 = 0;
  - slots 1..NUMBER_OF_BITS = tx_word[NUMBER_OF_BITS-1] down to tx_word[0];
  - remaining slots = 0.
- RIGHT repeats the same tx_word; no reload at RIGHT slot 0.
- On RIGHT's last slot:
  - If enable=1, go to LEFT slot 0.
  - Otherwise go to IDLE.
- enable deasserted mid-frame has no effect until the frame completes.
- Reset mid-frame aborts immediately: the next cycle shows reset values, and the held sample is discarded.
- The hold register keeps accepting in any state, including IDLE.
- Frame length is 2*WS_HALF_PERIOD cycles; one sample is consumed per frame.

Test Plan:
1. Reset values: hold rst_n=0 for 3 cycles, then release with enable=0 → ws=0, sd=0, in_ready=1, underrun=0 indefinitely.
2. Mean and serialization (NUM_CHANNELS=2, NUMBER_OF_BITS=8, WS_HALF_PERIOD=16):
   - Stimulus: in IDLE, load data_in={8'h20,8'h40} with in_valid for 1 cycle, then raise enable.
   - Response: in_ready drops the cycle after accept.
   - LEFT: ws=0 for 16 cycles, with sd on slots 1..8 = 0,0,1,1,0,0,0,0 (0x30) and 0 elsewhere.
   - RIGHT: ws=1 for 16 cycles with the identical bit pattern.
3. Negative rounding: data_in={8'hFF,8'h80} → tx word 0xBF (−65), so sd slots 1..8 = 1,0,1,1,1,1,1,1 in both halves.
4. Underrun: keep enable=1 with no in_valid → underrun pulses 1 cycle at each LEFT slot 0 (every 32 cycles), sd all 0, ws still toggles every 16 cycles.
5. Boundary accept and disable:
   - Stimulus: assert in_valid exactly in the cycle LEFT slot 0 is entered with the hold empty.
   - Response: that frame is zeros with underrun=1; the next frame carries the sample.
   - Then drop enable at LEFT slot 5 → the frame finishes all 32 slots, then IDLE with ws=0.
6. Reset mid-frame: assert rst_n=0 at RIGHT slot 4 while hold_valid=1 → the next cycle has ws=0, sd=0, in_ready=1, and after release no stale word is transmitted.

Source files
------------

// File: rtl/beam_sum_i2s_tx.sv
// ---------------------------------------------------------------------------
// beam_sum_i2s_tx
//
// Output stage of the beamformer. Takes one sample set (one PCM sample per
// channel) and averages it into a single beam sample. A one-deep holding
// register stores that sample. The frame engine then sends the held word as
// mono I2S: the same word goes out in the left half and again in the right
// half. Data is MSB first, starting one slot after each ws edge.
//
// Ports:
//   clk       - single clock, all state changes on posedge
//   rst_n     - synchronous active-low reset
//   enable    - run request, only looked at on frame boundaries (and in IDLE)
//   data_in   - NUM_CHANNELS packed samples, channel 0 in the LSBs
//   in_valid  - data_in carries a new sample set
//   in_ready  - holding register empty, a sample set will be accepted
//   sd        - I2S serial data
//   ws        - I2S word select, 0 = left half, 1 = right half
//   underrun  - one-cycle pulse when a frame starts with nothing held
// ---------------------------------------------------------------------------
module beam_sum_i2s_tx #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int NUM_CHANNELS   = 2,
  parameter int WS_HALF_PERIOD = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   enable,
  input  logic [NUM_CHANNELS*NUMBER_OF_BITS-1:0] data_in,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic                                   sd,
  output logic                                   ws,
  output logic                                   underrun
);

  localparam int LOG2_CH = $clog2(NUM_CHANNELS);
  localparam int SUM_W   = NUMBER_OF_BITS + LOG2_CH;
  localparam int SLOT_W  = $clog2(WS_HALF_PERIOD);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WS_HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t                      state, state_next;
  logic [SLOT_W-1:0]           slot, slot_next;
  logic [NUMBER_OF_BITS-1:0]   tx_word, tx_word_next;
  logic [NUMBER_OF_BITS-1:0]   hold, hold_next;
  logic                        hold_valid, hold_valid_next;
  logic                        sd_next, ws_next, underrun_next, in_ready_next;
  logic                        frame_start;

  logic signed [SUM_W-1:0]          acc;
  logic signed [SUM_W-1:0]          ch_ext;
  logic signed [NUMBER_OF_BITS-1:0] ch;
  logic [NUMBER_OF_BITS-1:0]        mean;

  // Channel average. The sum gets log2(NUM_CHANNELS) guard bits so it can
  // never wrap. The arithmetic shift floors toward minus infinity. After the
  // shift the result always fits back into NUMBER_OF_BITS.
  always_comb begin
    acc    = '0;
    ch     = '0;
    ch_ext = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ch     = data_in[i*NUMBER_OF_BITS +: NUMBER_OF_BITS];
      ch_ext = SUM_W'(ch);
      acc    = acc + ch_ext;
    end
    mean = NUMBER_OF_BITS'(acc >>> LOG2_CH);
  end

  // Frame sequencing, hold register handshake and next values of every
  // registered output.
  //
  // The hold register is loaded after the frame-start decision. A sample set
  // accepted in the same cycle as an empty frame start therefore does not go
  // out in that frame; it waits in the hold register for the next frame.
  //
  // The serial bit comes from the slot being entered. Because of that, sd
  // lines up with ws and the one-slot I2S delay without needing an extra
  // pipeline stage.
  always_comb begin
    state_next      = state;
    slot_next       = slot;
    tx_word_next    = tx_word;
    hold_next       = hold;
    hold_valid_next = hold_valid;
    underrun_next   = 1'b0;
    frame_start     = 1'b0;

    case (state)
      IDLE: begin
        if (enable) frame_start = 1'b1;
      end
      LEFT: begin
        if (slot == LAST_SLOT) begin
          state_next = RIGHT;
          slot_next  = '0;
        end else begin
          slot_next = slot + SLOT_W'(1);
        end
      end
      RIGHT: begin
        if (slot == LAST_SLOT) begin
          if (enable) begin
            frame_start = 1'b1;
          end else begin
            state_next = IDLE;
            slot_next  = '0;
          end
        end else begin
          slot_next = slot + SLOT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        slot_next  = '0;
      end
    endcase

    if (frame_start) begin
      state_next = LEFT;
      slot_next  = '0;
      if (hold_valid) begin
        tx_word_next    = hold;
        hold_valid_next = 1'b0;
      end else begin
        tx_word_next  = '0;
        underrun_next = 1'b1;
      end
    end

    if (in_valid && !hold_valid) begin
      hold_next       = mean;
      hold_valid_next = 1'b1;
    end

    ws_next       = (state_next == RIGHT);
    in_ready_next = !hold_valid_next;

    // Slot k (1..NUMBER_OF_BITS) carries tx_word bit NUMBER_OF_BITS-k.
    sd_next = 1'b0;
    if (state_next != IDLE) begin
      for (int b = 0; b < NUMBER_OF_BITS; b++) begin
        if (slot_next == SLOT_W'(NUMBER_OF_BITS - b)) sd_next = tx_word_next[b];
      end
    end
  end

  // State and output registers. Reset discards any held sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      slot       <= '0;
      tx_word    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      sd         <= 1'b0;
      ws         <= 1'b0;
      underrun   <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_next;
      slot       <= slot_next;
      tx_word    <= tx_word_next;
      hold       <= hold_next;
      hold_valid <= hold_valid_next;
      sd         <= sd_next;
      ws         <= ws_next;
      underrun   <= underrun_next;
      in_ready   <= in_ready_next;
    end
  end

endmodule
